// File: rtl/dpram_fifo_pkg.sv
// Shared constants and types for the dual-port-RAM FIFO controller.
package dpram_fifo_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // RAM pointer and total-occupancy types at the default geometry
    typedef logic [0:ADDR_W_DEF-1] ptr_t;
    typedef logic [0:ADDR_W_DEF]   cnt_t;
endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop handshake and external RAM port bundle for dpram_fifo_ctrl.
// Optional almost-full/almost-empty flags appear with FIFO_ALMOST_FLAGS_EN.
interface dpram_fifo_ctrl_if
    import dpram_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              push_valid;
    logic              push_ready;
    logic [0:DATA_W-1] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [0:DATA_W-1] pop_data;
    logic              ram_wen;
    logic [0:ADDR_W-1] ram_waddr;
    logic [0:DATA_W-1] ram_wdata;
    logic              ram_ren;
    logic [0:ADDR_W-1] ram_raddr;
    logic [0:DATA_W-1] ram_rdata;
    logic [0:ADDR_W]   count;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    // FIFO controller side
    modport slave (
        input  push_valid, push_data, pop_ready, ram_rdata,
        output push_ready, pop_valid, pop_data,
        output ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr, count
`ifdef FIFO_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );

    // Producer/consumer/RAM side
    modport master (
        output push_valid, push_data, pop_ready, ram_rdata,
        input  push_ready, pop_valid, pop_data,
        input  ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr, count
`ifdef FIFO_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );
endinterface

// File: rtl/fifo_ptr.sv
// Wrapping W-bit address counter with increment enable and async reset.
module fifo_ptr #(
    parameter int W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [0:W-1] ptr
);
    // Advance by one per enable; natural overflow wraps 2**W-1 -> 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ptr <= '0;
        else if (inc) ptr <= ptr + W'(1);
    end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM plus one registered
// output word. The RAM samples on the falling edge, so a read issued in a
// cycle returns data before the next rising edge.
// Optional macro: FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty.
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AF_LEVEL = 1020,
    parameter int AE_LEVEL = 4
) (
    input logic             clk,
    input logic             rst,
    dpram_fifo_ctrl_if.slave bus
);
    localparam logic [0:ADDR_W] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [0:ADDR_W] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [0:ADDR_W]   ram_cnt;
    logic [0:ADDR_W]   ram_cnt_next;
    logic [0:ADDR_W-1] wr_ptr;
    logic [0:ADDR_W-1] rd_ptr;
    logic              push_accept;
    logic              rd_en;
    logic              pop_valid_next;

    // ram_cnt is registered, so a word written this cycle is not readable
    // until the next one; this keeps same-address read/write apart.
    assign bus.push_ready = !rst && (ram_cnt != CNT_FULL);
    assign push_accept    = bus.push_valid && bus.push_ready;
    assign rd_en          = !rst && (ram_cnt != '0) && (!bus.pop_valid || bus.pop_ready);

    assign bus.ram_wen   = push_accept;
    assign bus.ram_waddr = wr_ptr;
    assign bus.ram_wdata = bus.push_data;
    assign bus.ram_ren   = rd_en;
    assign bus.ram_raddr = rd_ptr;

    fifo_ptr #(.W(ADDR_W)) u_wr_ptr (.clk(clk), .rst(rst), .inc(push_accept), .ptr(wr_ptr));
    fifo_ptr #(.W(ADDR_W)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_en),       .ptr(rd_ptr));

    // Next-state occupancy of the RAM and of the output register
    always_comb begin
        ram_cnt_next = ram_cnt;
        case ({push_accept, rd_en})
            2'b10:   ram_cnt_next = ram_cnt + CNT_ONE;
            2'b01:   ram_cnt_next = ram_cnt - CNT_ONE;
            default: ram_cnt_next = ram_cnt;
        endcase
        pop_valid_next = bus.pop_valid;
        if (rd_en)                              pop_valid_next = 1'b1;
        else if (bus.pop_valid && bus.pop_ready) pop_valid_next = 1'b0;
    end

    // RAM word count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ram_cnt <= '0;
        else     ram_cnt <= ram_cnt_next;
    end

    // Output register: refilled from RAM on read, emptied on a bare pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pop_valid <= 1'b0;
            bus.pop_data  <= '0;
        end else begin
            bus.pop_valid <= pop_valid_next;
            if (rd_en) bus.pop_data <= bus.ram_rdata;
        end
    end

    assign bus.count = ram_cnt + {{ADDR_W{1'b0}}, bus.pop_valid};

`ifdef FIFO_ALMOST_FLAGS_EN
    logic [0:ADDR_W] count_next;
    assign count_next = ram_cnt_next + {{ADDR_W{1'b0}}, pop_valid_next};

    // Flags registered from next-state count so they line up with count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.almost_full  <= 1'b0;
            bus.almost_empty <= 1'b1;
        end else begin
            bus.almost_full  <= (count_next >= (ADDR_W+1)'(AF_LEVEL));
            bus.almost_empty <= (count_next <= (ADDR_W+1)'(AE_LEVEL));
        end
    end
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed testbench for dpram_fifo_ctrl with a falling-edge RAM model.
// Flag checks are compiled when FIFO_ALMOST_FLAGS_EN is defined.
module tb_dpram_fifo_ctrl;
    import dpram_fifo_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    dpram_fifo_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dpram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AF_LEVEL(1020), .AE_LEVEL(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [0:DW-1] mem [0:(1<<AW)-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write and read both captured on the falling edge
    always @(negedge clk) begin
        if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
        if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.push_valid = 1'b0;
        bus.pop_ready = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data = 32'h1234_5678;
        bus.pop_ready = 1'b1;
        tick(); tick();
        vectors++;
        if (bus.push_ready !== 1'b0) begin miscompares++; $display("FAIL rst_push_ready: got %b want 0", bus.push_ready); end
        vectors++;
        if (bus.ram_wen !== 1'b0 || bus.ram_ren !== 1'b0) begin miscompares++; $display("FAIL rst_ram_en: got wen=%b ren=%b want 0 0", bus.ram_wen, bus.ram_ren); end
        vectors++;
        if (bus.count !== 11'd0 || bus.pop_valid !== 1'b0 || bus.pop_data !== 32'h0) begin
            miscompares++; $display("FAIL rst_state: got count=%0d pv=%b pd=%h want 0 0 0", bus.count, bus.pop_valid, bus.pop_data);
        end
`ifdef FIFO_ALMOST_FLAGS_EN
        vectors++;
        if (bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b1) begin miscompares++; $display("FAIL rst_flags: got af=%b ae=%b want 0 1", bus.almost_full, bus.almost_empty); end
`endif
        rst = 1'b0;
        bus.push_valid = 1'b0;
        bus.pop_ready = 1'b0;
    endtask

    task automatic test_first_word();
        do_reset();
        tick();
        bus.push_valid = 1'b1;
        bus.push_data = 32'hA5A5_A5A5;
        #1;
        vectors++;
        if (bus.ram_wen !== 1'b1 || bus.ram_waddr !== 10'd0 || bus.ram_ren !== 1'b0) begin
            miscompares++; $display("FAIL first_write: got wen=%b waddr=%0d ren=%b want 1 0 0", bus.ram_wen, bus.ram_waddr, bus.ram_ren);
        end
        tick();
        bus.push_valid = 1'b0;
        #1;
        vectors++;
        if (bus.ram_ren !== 1'b1 || bus.ram_raddr !== 10'd0 || bus.pop_valid !== 1'b0) begin
            miscompares++; $display("FAIL first_read: got ren=%b raddr=%0d pv=%b want 1 0 0", bus.ram_ren, bus.ram_raddr, bus.pop_valid);
        end
        tick();
        #1;
        vectors++;
        if (bus.pop_valid !== 1'b1 || bus.pop_data !== 32'hA5A5_A5A5 || bus.count !== 11'd1) begin
            miscompares++; $display("FAIL first_pop: got pv=%b pd=%h count=%0d want 1 a5a5a5a5 1", bus.pop_valid, bus.pop_data, bus.count);
        end
    endtask

    task automatic test_fill();
        cnt_t c;
        do_reset();
        bus.pop_ready = 1'b0;
        for (int i = 0; i < 1025; i++) begin
            tick();
            bus.push_valid = 1'b1;
            bus.push_data = 32'(i);
            #1;
            vectors++;
            if (bus.ram_wen !== 1'b1 || bus.ram_waddr !== 10'(i)) begin
                miscompares++; $display("FAIL fill_push%0d: got wen=%b waddr=%0d want 1 %0d", i, bus.ram_wen, bus.ram_waddr, i % 1024);
            end
        end
        tick();
        c = 11'd1025;
        vectors++;
        if (bus.count !== c || bus.push_ready !== 1'b0) begin
            miscompares++; $display("FAIL fill_full: got count=%0d pr=%b want 1025 0", bus.count, bus.push_ready);
        end
        bus.push_data = 32'hDEAD_DEAD;
        #1;
        vectors++;
        if (bus.ram_wen !== 1'b0) begin miscompares++; $display("FAIL fill_overflow_wen: got %b want 0", bus.ram_wen); end
        tick();
        bus.push_valid = 1'b0;
        #1;
        vectors++;
        if (bus.count !== c) begin miscompares++; $display("FAIL fill_overflow_count: got %0d want 1025", bus.count); end
    endtask

    task automatic test_full_pop();
        bus.pop_ready = 1'b1;
        #1;
        vectors++;
        if (bus.pop_valid !== 1'b1 || bus.pop_data !== 32'd0 || bus.ram_ren !== 1'b1 || bus.ram_raddr !== 10'd1) begin
            miscompares++; $display("FAIL fullpop_head: got pv=%b pd=%h ren=%b raddr=%0d want 1 0 1 1", bus.pop_valid, bus.pop_data, bus.ram_ren, bus.ram_raddr);
        end
        tick();
        bus.pop_ready = 1'b0;
        #1;
        vectors++;
        if (bus.push_ready !== 1'b1 || bus.pop_data !== 32'd1 || bus.count !== 11'd1024) begin
            miscompares++; $display("FAIL fullpop_after: got pr=%b pd=%h count=%0d want 1 1 1024", bus.push_ready, bus.pop_data, bus.count);
        end
        bus.push_valid = 1'b1;
        bus.push_data = 32'h0000_BEEF;
        #1;
        vectors++;
        if (bus.ram_wen !== 1'b1 || bus.ram_waddr !== 10'd1) begin
            miscompares++; $display("FAIL fullpop_refill: got wen=%b waddr=%0d want 1 1", bus.ram_wen, bus.ram_waddr);
        end
        tick();
        bus.push_valid = 1'b0;
        #1;
        vectors++;
        if (bus.count !== 11'd1025) begin miscompares++; $display("FAIL fullpop_count: got %0d want 1025", bus.count); end
    endtask

    task automatic test_back_to_back();
        int exp_idx;
        exp_idx = 0;
        do_reset();
        bus.pop_ready = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            bus.push_valid = 1'b1;
            bus.push_data = 32'h1000_0000 + 32'(k);
            #1;
            vectors++;
            if (bus.ram_waddr !== 10'(k)) begin
                miscompares++; $display("FAIL b2b_waddr%0d: got %0d want %0d", k, bus.ram_waddr, k % 1024);
            end
            if (bus.pop_valid === 1'b1) begin
                vectors++;
                if (bus.pop_data !== 32'h1000_0000 + 32'(exp_idx)) begin
                    miscompares++; $display("FAIL b2b_data%0d: got %h want %h", k, bus.pop_data, 32'h1000_0000 + 32'(exp_idx));
                end
                exp_idx++;
            end
            if (k >= 2) begin
                vectors++;
                if (bus.count !== 11'd2) begin miscompares++; $display("FAIL b2b_count%0d: got %0d want 2", k, bus.count); end
            end
        end
        vectors++;
        if (exp_idx != 2998) begin miscompares++; $display("FAIL b2b_pops: got %0d want 2998", exp_idx); end
        tick();
        bus.push_valid = 1'b0;
        bus.pop_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.pop_ready = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            bus.push_valid = 1'b1;
            bus.push_data = 32'h2000_0000 + 32'(i);
        end
        tick();
        bus.push_valid = 1'b0;
        #1;
        vectors++;
        if (bus.count !== 11'd500) begin miscompares++; $display("FAIL midrst_pre_count: got %0d want 500", bus.count); end
        #2;
        rst = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data = 32'h0000_0077;
        #1;
        vectors++;
        if (bus.count !== 11'd0 || bus.pop_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_clear: got count=%0d pv=%b want 0 0", bus.count, bus.pop_valid);
        end
        vectors++;
        if (bus.push_ready !== 1'b0 || bus.ram_wen !== 1'b0 || bus.ram_ren !== 1'b0) begin
            miscompares++; $display("FAIL midrst_gate: got pr=%b wen=%b ren=%b want 0 0 0", bus.push_ready, bus.ram_wen, bus.ram_ren);
        end
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.ram_wen !== 1'b1 || bus.ram_waddr !== 10'd0) begin
            miscompares++; $display("FAIL midrst_repush: got wen=%b waddr=%0d want 1 0", bus.ram_wen, bus.ram_waddr);
        end
        tick();
        bus.push_valid = 1'b0;
    endtask

`ifdef FIFO_ALMOST_FLAGS_EN
    task automatic test_almost_flags();
        do_reset();
        bus.pop_ready = 1'b0;
        for (int i = 0; i < 1020; i++) begin
            tick();
            bus.push_valid = 1'b1;
            bus.push_data = 32'(i);
            #1;
            if (i == 1018) begin
                vectors++;
                if (bus.almost_full !== 1'b0) begin miscompares++; $display("FAIL af_at_1019: got %b want 0", bus.almost_full); end
            end
        end
        tick();
        bus.push_valid = 1'b0;
        #1;
        vectors++;
        if (bus.count !== 11'd1020 || bus.almost_full !== 1'b1) begin
            miscompares++; $display("FAIL af_at_1020: got count=%0d af=%b want 1020 1", bus.count, bus.almost_full);
        end
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 1016; i++) begin
            tick();
            if (i == 1014) begin
                vectors++;
                if (bus.almost_empty !== 1'b0 || bus.count !== 11'd5) begin
                    miscompares++; $display("FAIL ae_at_5: got count=%0d ae=%b want 5 0", bus.count, bus.almost_empty);
                end
            end
        end
        bus.pop_ready = 1'b0;
        #1;
        vectors++;
        if (bus.count !== 11'd4 || bus.almost_empty !== 1'b1) begin
            miscompares++; $display("FAIL ae_at_4: got count=%0d ae=%b want 4 1", bus.count, bus.almost_empty);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_data = '0;
        bus.pop_ready = 1'b0;
        test_reset();
        test_first_word();
        test_fill();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
`ifdef FIFO_ALMOST_FLAGS_EN
        test_almost_flags();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, RAM address width; RAM depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter AF_LEVEL, default 1020, almost-full threshold on count.
REQ-004 Parameter AE_LEVEL, default 4, almost-empty threshold on count.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 push_valid  input  1  write request.
REQ-008 push_ready  output  1  FIFO can accept a word.
REQ-009 push_data  input  [0:DATA_W-1]  write word.
REQ-010 pop_valid  output  1  pop_data holds the head word.
REQ-011 pop_ready  input  1  consumer takes the head word.
REQ-012 pop_data  output  [0:DATA_W-1]  head word, registered.
REQ-013 ram_wen  output  1  RAM write enable.
REQ-014 ram_waddr  output  [0:ADDR_W-1]  RAM write address.
REQ-015 ram_wdata  output  [0:DATA_W-1]  RAM write data.
REQ-016 ram_ren  output  1  RAM read enable.
REQ-017 ram_raddr  output  [0:ADDR_W-1]  RAM read address.
REQ-018 ram_rdata  input  [0:DATA_W-1]  RAM read data; RAM captures on clk falling edge.
REQ-019 count  output  [0:ADDR_W]  total words held (RAM plus output register).

Function
REQ-020 Push accepted when push_valid && push_ready.
- On accept: ram_wen=1, ram_waddr=wr_ptr, ram_wdata=push_data, all combinational.
REQ-021 push_ready = (ram_cnt != 2**ADDR_W).
- ram_cnt is the registered count of words held in RAM.
REQ-022 Pop occurs when pop_valid && pop_ready.
REQ-023 ram_ren = (ram_cnt != 0) && (!pop_valid || pop_ready).
- ram_raddr = rd_ptr.
- ram_cnt is registered, so a word written in cycle N is never read in cycle N.
REQ-024 When ram_ren=1 in cycle N: pop_data <= ram_rdata and pop_valid <= 1 at the end of cycle N.
REQ-025 Pop without ram_ren: pop_valid <= 0 and pop_data holds its value.
REQ-026 Pointer wrap: wr_ptr increments per accepted push, rd_ptr increments per ram_ren; both wrap from 2**ADDR_W-1 to 0.
REQ-027 ram_cnt next value = ram_cnt + push_accept - ram_ren.
- Simultaneous push and ram_ren leaves ram_cnt unchanged.
REQ-028 count = ram_cnt + pop_valid; maximum capacity is 2**ADDR_W+1.
REQ-029 Latency: push accepted in cycle N on an empty FIFO gives pop_valid=1 in cycle N+2.
REQ-030 Sustained throughput is one push and one pop per cycle.
REQ-031 Push when full is ignored: no RAM write, no pointer change.
- Pop when pop_valid=0 is ignored.

Reset
REQ-032 rst clears wr_ptr, rd_ptr, ram_cnt, pop_valid and pop_data to 0 immediately, regardless of clk.
REQ-033 During rst: push_ready=0, ram_wen=0, ram_ren=0.
REQ-034 Reset mid-operation discards all contents; RAM data is not cleared.

Configuration
REQ-035 FIFO_ALMOST_FLAGS_EN defined:
- Adds output almost_full = (count >= AF_LEVEL), registered, reset 0.
- Adds output almost_empty = (count <= AE_LEVEL), registered, reset 1.
REQ-036 FIFO_ALMOST_FLAGS_EN undefined: both ports and their logic are absent; all other behaviour is identical.

Structure
REQ-037 Shared package dpram_fifo_pkg holds:
- default ADDR_W and DATA_W constants;
- the pointer typedef;
- the count typedef.
REQ-038 Sub-module fifo_ptr (wrapping ADDR_W-bit counter with increment enable and async reset) is instantiated twice, for wr_ptr and rd_ptr.

Verification
REQ-039 Reset, then push 0xA5A5A5A5 in cycle 1 -> ram_wen=1, waddr=0 in cycle 1; ram_ren=1, raddr=0 in cycle 2; pop_valid=1, pop_data=0xA5A5A5A5 in cycle 3.
REQ-040 Push 1025 words with pop_ready=0 -> push_ready=0 after the 1025th push, count=1025; the 1026th push causes no write.
REQ-041 Steady state, push and pop every cycle for 3000 cycles -> data in order, count constant, pointers wrap past 1023 without loss.
REQ-042 Full FIFO, single pop -> push_ready=1 next cycle; push accepted and written at waddr equal to the freed slot.
REQ-043 rst asserted mid-stream with count=500 -> count=0 and pop_valid=0 immediately; next push is written at waddr=0.
REQ-044 With FIFO_ALMOST_FLAGS_EN: fill to 1020 -> almost_full=1; drain to 4 -> almost_empty=1.
